comp_weight_loader: RTL

COMP_WEIGHT_LOADER -- requirements
Module: comp_weight_loader

---
 rtl/comp_weight_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/comp_weight_loader.sv
// Preloads one column of compensation weights from memory into a CPE column,
// reading rows top-down so the last weight shifted in settles in row 0.
module comp_weight_loader #(
    parameter int unsigned NUM_ROWS   = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [3:0]            mem_rd_data,
    output logic [3:0]            Compensation_Weight,
    output logic                  Compensation_Weight_out_valid,
    output logic                  act_hold,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CNT_W = $clog2(NUM_ROWS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd_en_d1_q, rd_en_d1_d;
    logic [3:0]            weight_q, weight_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  act_hold_q, act_hold_d;

    // Next-state logic; outputs are registered from the next state so they
    // line up with the state they describe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    cnt_d   = CNT_W'(NUM_ROWS - 1);
                    base_d  = base_addr;
                end
            end
            S_READ: begin
                if (cnt_q == '0) begin
                    state_d = S_DRAIN;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        rd_en_d    = (state_d == S_READ);
        addr_d     = rd_en_d ? ADDR_WIDTH'(base_d + ADDR_WIDTH'(cnt_d)) : '0;
        // Memory answers one cycle after the strobe; capture it one cycle later.
        rd_en_d1_d = rd_en_q;
        valid_d    = rd_en_d1_q;
        weight_d   = rd_en_d1_q ? mem_rd_data : weight_q;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        act_hold_d = busy_d | valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            base_q     <= '0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            rd_en_d1_q <= 1'b0;
            weight_q   <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            act_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            rd_en_d1_q <= rd_en_d1_d;
            weight_q   <= weight_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            act_hold_q <= act_hold_d;
        end
    end

    assign mem_rd_en                     = rd_en_q;
    assign mem_addr                      = addr_q;
    assign Compensation_Weight           = weight_q;
    assign Compensation_Weight_out_valid = valid_q;
    assign act_hold                      = act_hold_q;
    assign busy                          = busy_q;
    assign done                          = done_q;

endmodule
